// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: shared rggen access/status encodings and the Avalon bridge state type.
package rggen_rtl_pkg;
    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RESPONSE,
        DONE
    } rggen_avalon_bridge_state;
endpackage

// File: rtl/rggen_avalon_if.sv
// rggen_avalon_if: Avalon-MM host/agent interface with pipelined read and write responses.
interface rggen_avalon_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) ();
    logic                     read;
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH/8-1:0]  byteenable;
    logic [DATA_WIDTH-1:0]    writedata;
    logic                     waitrequest;
    logic                     readdatavalid;
    logic                     writeresponsevalid;
    logic [1:0]               response;
    logic [DATA_WIDTH-1:0]    readdata;

    modport host (
        output read, write, address, byteenable, writedata,
        input  waitrequest, readdatavalid, writeresponsevalid, response, readdata
    );

    modport agent (
        input  read, write, address, byteenable, writedata,
        output waitrequest, readdatavalid, writeresponsevalid, response, readdata
    );
endinterface

// File: rtl/rggen_bus_if.sv
// rggen_bus_if: rggen register-bus request/response interface.
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
) ();
    logic                     valid;
    rggen_access              access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_timeout_counter.sv
// rggen_timeout_counter: flags the COUNT-th consecutive enabled cycle since the last clear.
module rggen_timeout_counter #(
    parameter int COUNT = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [15:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst || clear) count <= '0;
        else if (enable)    count <= count + 16'd1;
    end

    assign expired = enable && (count == 16'(COUNT - 1));
endmodule

// File: rtl/rggen_avalon_pipelined_bridge.sv
// rggen_avalon_pipelined_bridge: one-at-a-time rggen bus to Avalon-MM host with pipelined responses.
// Optional transaction timeout enabled by defining RGGEN_AVALON_BRIDGE_TIMEOUT_EN.
module rggen_avalon_pipelined_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 32,
    parameter int READ_STROBE    = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic         i_clk,
    input logic         i_rst,
    rggen_bus_if.slave  bus_if,
    rggen_avalon_if.host avalon_if
);
    rggen_avalon_bridge_state state;
    logic is_read;
    logic timeout;
    logic stale;
    logic cmd_read;
    logic rsp_valid;
    logic any_valid;

    assign cmd_read  = bus_if.access == RGGEN_READ;
    assign any_valid = avalon_if.readdatavalid || avalon_if.writeresponsevalid;
    assign rsp_valid = !stale && (is_read ? avalon_if.readdatavalid : avalon_if.writeresponsevalid);

`ifdef RGGEN_AVALON_BRIDGE_TIMEOUT_EN
    rggen_timeout_counter #(.COUNT(TIMEOUT_CYCLES)) u_timeout (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clear   (state == IDLE),
        .enable  (state == REQUEST || state == RESPONSE),
        .expired (timeout)
    );

    // An abandoned response may still arrive later; swallow exactly one valid.
    always_ff @(posedge i_clk) begin
        if (i_rst)                            stale <= 1'b0;
        else if (timeout && state == RESPONSE) stale <= 1'b1;
        else if (any_valid)                   stale <= 1'b0;
    end
`else
    logic [15:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
    assign stale   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                <= IDLE;
            is_read              <= 1'b0;
            avalon_if.read       <= 1'b0;
            avalon_if.write      <= 1'b0;
            avalon_if.address    <= '0;
            avalon_if.byteenable <= '0;
            avalon_if.writedata  <= '0;
            bus_if.ready         <= 1'b0;
            bus_if.status        <= RGGEN_OKAY;
            bus_if.read_data     <= '0;
        end else if (timeout) begin
            state            <= DONE;
            avalon_if.read   <= 1'b0;
            avalon_if.write  <= 1'b0;
            bus_if.ready     <= 1'b1;
            bus_if.status    <= RGGEN_SLAVE_ERROR;
            bus_if.read_data <= '0;
        end else begin
            case (state)
                IDLE: if (bus_if.valid) begin
                    state                <= REQUEST;
                    is_read              <= cmd_read;
                    avalon_if.read       <= cmd_read;
                    avalon_if.write      <= !cmd_read;
                    avalon_if.address    <= ADDRESS_WIDTH'(bus_if.address);
                    avalon_if.byteenable <= (!cmd_read || READ_STROBE != 0) ? bus_if.strobe : '1;
                    avalon_if.writedata  <= bus_if.write_data;
                end
                REQUEST: if (!avalon_if.waitrequest) begin
                    state           <= RESPONSE;
                    avalon_if.read  <= 1'b0;
                    avalon_if.write <= 1'b0;
                end
                RESPONSE: if (rsp_valid) begin
                    state            <= DONE;
                    bus_if.ready     <= 1'b1;
                    bus_if.status    <= rggen_status'(avalon_if.response);
                    bus_if.read_data <= is_read ? avalon_if.readdata : '0;
                end
                default: begin
                    state        <= IDLE;
                    bus_if.ready <= 1'b0;
                end
            endcase
        end
    end
endmodule
